// File: rtl/acc_cpu_core.sv
// Multicycle accumulator CPU: FETCH/MEM/EXEC sequencing over a synchronous
// instruction memory (with a load port) and a synchronous data memory.
module acc_cpu_core #(
    parameter int DATA_W = 32,
    parameter int IM_AW  = 4,
    parameter int DM_AW  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              im_we,
    input  logic [IM_AW-1:0]  im_waddr,
    input  logic [31:0]       im_wdata,
    output logic [31:0]       inst,
    output logic [IM_AW-1:0]  pc,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic              zero,
    output logic              halted,
    output logic              illegal,
    output logic [15:0]       retired
);

    localparam int IM_DEPTH = 2 ** IM_AW;
    localparam int DM_DEPTH = 2 ** DM_AW;

    localparam logic [6:0] OP_NOP  = 7'd0;
    localparam logic [6:0] OP_LD   = 7'd1;
    localparam logic [6:0] OP_ST   = 7'd2;
    localparam logic [6:0] OP_ADD  = 7'd3;
    localparam logic [6:0] OP_SUB  = 7'd4;
    localparam logic [6:0] OP_XOR  = 7'd5;
    localparam logic [6:0] OP_AND  = 7'd6;
    localparam logic [6:0] OP_OR   = 7'd7;
    localparam logic [6:0] OP_ADDI = 7'd8;
    localparam logic [6:0] OP_LDI  = 7'd9;
    localparam logic [6:0] OP_BEQZ = 7'd10;
    localparam logic [6:0] OP_BNEZ = 7'd11;
    localparam logic [6:0] OP_JMP  = 7'd12;
    localparam logic [6:0] OP_HALT = 7'd13;

    typedef enum logic [1:0] {
        S_FETCH,
        S_MEM,
        S_EXEC,
        S_HALT
    } state_t;

    state_t state, state_next;

    logic [31:0]       im [IM_DEPTH];
    logic [DATA_W-1:0] dm [DM_DEPTH];
    logic [DATA_W-1:0] md;

    logic [6:0]        op;
    logic [DM_AW-1:0]  dma;
    logic [DATA_W-1:0] imm;
    logic [IM_AW-1:0]  tgt;

    logic [IM_AW-1:0]  pc_next;
    logic [DATA_W-1:0] acc_next;
    logic              carry_next;
    logic [31:0]       inst_next;
    logic [15:0]       retired_next;
    logic              illegal_next;
    logic              dm_we;
    logic [DATA_W:0]   wide;

    assign op     = inst[6:0];
    assign dma    = inst[7 +: DM_AW];
    assign imm    = DATA_W'($signed(inst[31:20]));
    assign tgt    = inst[20 +: IM_AW];
    assign zero   = (acc == '0);
    assign halted = (state == S_HALT);

    // Instruction memory load port; the FETCH read of the same word sees the old contents.
    always_ff @(posedge clock) begin
        if (im_we) begin
            im[im_waddr] <= im_wdata;
        end
    end

    // Data memory: registered operand read in MEM, store on the EXEC edge.
    always_ff @(posedge clock) begin
        if (state == S_MEM) begin
            md <= dm[dma];
        end
        if (dm_we) begin
            dm[dma] <= acc;
        end
    end

    // Architectural state register; asynchronous reset aborts any instruction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= '0;
            acc     <= '0;
            inst    <= '0;
            carry   <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            acc     <= acc_next;
            inst    <= inst_next;
            carry   <= carry_next;
            illegal <= illegal_next;
            retired <= retired_next;
        end
    end

    // Sequencing and execute datapath: next state and next architectural values.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        acc_next     = acc;
        carry_next   = carry;
        inst_next    = inst;
        retired_next = retired;
        illegal_next = illegal;
        dm_we        = 1'b0;
        wide         = '0;

        case (state)
            S_FETCH: begin
                if (run) begin
                    inst_next  = im[pc];
                    state_next = S_MEM;
                end
            end
            S_MEM: begin
                state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next   = S_FETCH;
                pc_next      = pc + IM_AW'(1);
                retired_next = retired + 16'd1;
                case (op)
                    OP_NOP: ;
                    OP_LD:  acc_next = md;
                    OP_ST:  dm_we = 1'b1;
                    OP_ADD: begin
                        wide       = {1'b0, acc} + {1'b0, md};
                        acc_next   = wide[DATA_W-1:0];
                        carry_next = wide[DATA_W];
                    end
                    OP_SUB: begin
                        // Top bit of the widened difference is the borrow.
                        wide       = {1'b0, acc} - {1'b0, md};
                        acc_next   = wide[DATA_W-1:0];
                        carry_next = wide[DATA_W];
                    end
                    OP_XOR: acc_next = acc ^ md;
                    OP_AND: acc_next = acc & md;
                    OP_OR:  acc_next = acc | md;
                    OP_ADDI: begin
                        wide       = {1'b0, acc} + {1'b0, imm};
                        acc_next   = wide[DATA_W-1:0];
                        carry_next = wide[DATA_W];
                    end
                    OP_LDI:  acc_next = imm;
                    OP_BEQZ: if (zero)  pc_next = tgt;
                    OP_BNEZ: if (!zero) pc_next = tgt;
                    OP_JMP:  pc_next = tgt;
                    OP_HALT: begin
                        pc_next    = pc;
                        state_next = S_HALT;
                    end
                    default: begin
                        pc_next      = pc;
                        illegal_next = 1'b1;
                        state_next   = S_HALT;
                    end
                endcase
            end
            S_HALT: ;
            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed and randomized program checks of acc_cpu_core against an ISA-level model.
module tb_acc_cpu_core;

    localparam int DATA_W = 32;
    localparam int IM_AW  = 4;
    localparam int DM_AW  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        im_we = 1'b0;
    logic [3:0]  im_waddr = '0;
    logic [31:0] im_wdata = '0;
    logic [31:0] inst;
    logic [3:0]  pc;
    logic [31:0] acc;
    logic        carry, zero, halted, illegal;
    logic [15:0] retired;

    acc_cpu_core #(.DATA_W(DATA_W), .IM_AW(IM_AW), .DM_AW(DM_AW)) dut (
        .clock(clock), .reset(reset), .run(run), .im_we(im_we),
        .im_waddr(im_waddr), .im_wdata(im_wdata), .inst(inst), .pc(pc),
        .acc(acc), .carry(carry), .zero(zero), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_im [16];
    logic [31:0] m_dm [16];
    logic [31:0] e_acc;
    logic        e_carry, e_halt, e_ill;
    logic [3:0]  e_pc;
    int          e_ret;

    function automatic logic [31:0] e_mem(input logic [6:0] op, input logic [3:0] a);
        return {21'd0, a, op};
    endfunction

    function automatic logic [31:0] e_imm(input logic [6:0] op, input logic [11:0] v);
        return {v, 13'd0, op};
    endfunction

    function automatic logic [31:0] e_br(input logic [6:0] op, input logic [3:0] t);
        return {8'd0, t, 13'd0, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_im();
        for (int unsigned i = 0; i < 16; i++) m_im[i] = '0;
    endtask

    task automatic reset_core();
        @(negedge clock);
        reset = 1'b1;
        run   = 1'b0;
        im_we = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic load_im();
        for (int unsigned i = 0; i < 16; i++) begin
            @(negedge clock);
            im_we    = 1'b1;
            im_waddr = 4'(i);
            im_wdata = m_im[i];
        end
        @(negedge clock);
        im_we = 1'b0;
    endtask

    task automatic go(input int budget, output int cyc);
        cyc = 0;
        run = 1'b1;
        while (halted !== 1'b1 && cyc < budget) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        n_cmp++;
        assert (halted === 1'b1) else begin
            n_err++;
            $error("FAIL halt_timeout: observed=%0d cycles expected halted", cyc);
        end
    endtask

    // Instruction-level interpreter: one loop iteration per architectural instruction.
    task automatic model_run();
        logic [31:0] a, w, imm, d;
        logic [32:0] s;
        logic [3:0]  p, nx;
        logic        c, h, il;
        int          r;
        a = '0; c = 1'b0; p = '0; r = 0; h = 1'b0; il = 1'b0;
        for (int unsigned step = 0; step < 1000 && !h; step++) begin
            w   = m_im[p];
            imm = {{20{w[31]}}, w[31:20]};
            d   = m_dm[w[10:7]];
            nx  = p + 4'd1;
            case (w[6:0])
                7'd0:  ;
                7'd1:  a = d;
                7'd2:  m_dm[w[10:7]] = a;
                7'd3:  begin s = {1'b0, a} + {1'b0, d}; a = s[31:0]; c = s[32]; end
                7'd4:  begin c = (a < d); a = a - d; end
                7'd5:  a = a ^ d;
                7'd6:  a = a & d;
                7'd7:  a = a | d;
                7'd8:  begin s = {1'b0, a} + {1'b0, imm}; a = s[31:0]; c = s[32]; end
                7'd9:  a = imm;
                7'd10: if (a == 0) nx = w[23:20];
                7'd11: if (a != 0) nx = w[23:20];
                7'd12: nx = w[23:20];
                7'd13: begin h = 1'b1; nx = p; end
                default: begin h = 1'b1; il = 1'b1; nx = p; end
            endcase
            r++;
            p = nx;
        end
        e_acc = a; e_carry = c; e_pc = p; e_ret = r; e_halt = h; e_ill = il;
    endtask

    task automatic check_model(input string tag, input int cyc);
        chk({tag, "/acc"}, acc, e_acc);
        chk({tag, "/carry"}, 32'(carry), 32'(e_carry));
        chk({tag, "/zero"}, 32'(zero), 32'(e_acc == 0));
        chk({tag, "/pc"}, 32'(pc), 32'(e_pc));
        chk({tag, "/halted"}, 32'(halted), 32'(e_halt));
        chk({tag, "/illegal"}, 32'(illegal), 32'(e_ill));
        chk({tag, "/retired"}, 32'(retired), 32'(e_ret));
        chk({tag, "/cycles"}, 32'(cyc), 32'(3 * e_ret));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "/inst"}, inst, 32'd0);
        chk({tag, "/pc"}, 32'(pc), 32'd0);
        chk({tag, "/acc"}, acc, 32'd0);
        chk({tag, "/carry"}, 32'(carry), 32'd0);
        chk({tag, "/zero"}, 32'(zero), 32'd1);
        chk({tag, "/halted"}, 32'(halted), 32'd0);
        chk({tag, "/illegal"}, 32'(illegal), 32'd0);
        chk({tag, "/retired"}, 32'(retired), 32'd0);
    endtask

    task automatic run_prog(input string tag);
        int cyc;
        reset_core();
        load_im();
        go(200, cyc);
        model_run();
        check_model(tag, cyc);
    endtask

    initial begin
        int          cyc;
        logic [31:0] rv;
        logic [6:0]  op;
        logic [31:0] jmp_word, addi_word;

        reset_core();
        check_reset("por");

        // Give every DM word a known value: LDI/ST pairs, then HALT.
        for (int unsigned chunk = 0; chunk < 3; chunk++) begin
            clear_im();
            for (int unsigned k = 0; k < 7; k++) begin
                if (chunk * 7 + k < 16) begin
                    rv = $urandom();
                    m_im[2 * k]     = e_imm(7'd9, rv[11:0]);
                    m_im[2 * k + 1] = e_mem(7'd2, 4'(chunk * 7 + k));
                end else begin
                    m_im[2 * k]     = '0;
                    m_im[2 * k + 1] = '0;
                end
            end
            m_im[14] = e_mem(7'd13, 4'd0);
            run_prog("dm_init");
        end

        // LDI 5; ST 3; ADD 3; HALT
        clear_im();
        m_im[0] = e_imm(7'd9, 12'd5);
        m_im[1] = e_mem(7'd2, 4'd3);
        m_im[2] = e_mem(7'd3, 4'd3);
        m_im[3] = e_mem(7'd13, 4'd0);
        run_prog("basic");
        chk("basic/acc10", acc, 32'd10);
        chk("basic/cyc12", 32'(3 * e_ret), 32'd12);
        repeat (5) begin @(posedge clock); #1; end
        chk("halt_hold/pc", 32'(pc), 32'd3);
        chk("halt_hold/retired", 32'(retired), 32'd4);
        run = 1'b0;

        // LDI 1; ST 5; LDI -1; ADDI 1; HALT
        clear_im();
        m_im[0] = e_imm(7'd9, 12'd1);
        m_im[1] = e_mem(7'd2, 4'd5);
        m_im[2] = e_imm(7'd9, 12'hFFF);
        m_im[3] = e_imm(7'd8, 12'd1);
        m_im[4] = e_mem(7'd13, 4'd0);
        run_prog("addi_wrap");
        chk("addi_wrap/carry1", 32'(carry), 32'd1);
        chk("addi_wrap/zero1", 32'(zero), 32'd1);

        // SUB 5 from acc=0 with DM[5]=1
        clear_im();
        m_im[0] = e_mem(7'd4, 4'd5);
        m_im[1] = e_mem(7'd13, 4'd0);
        run_prog("sub_borrow");
        chk("sub_borrow/acc", acc, 32'hFFFF_FFFF);
        chk("sub_borrow/carry1", 32'(carry), 32'd1);
        chk("sub_borrow/zero0", 32'(zero), 32'd0);

        // Countdown loop
        clear_im();
        m_im[0] = e_imm(7'd9, 12'd3);
        m_im[1] = e_imm(7'd8, 12'hFFF);
        m_im[2] = e_br(7'd11, 4'd1);
        m_im[3] = e_mem(7'd13, 4'd0);
        run_prog("loop");
        chk("loop/retired8", 32'(retired), 32'd8);
        chk("loop/acc0", acc, 32'd0);

        // Undefined opcode at pc=2
        clear_im();
        m_im[0] = e_imm(7'd9, 12'h02A);
        m_im[2] = 32'h0000_0055;
        run_prog("illegal");
        chk("illegal/flag", 32'(illegal), 32'd1);
        chk("illegal/pc2", 32'(pc), 32'd2);
        chk("illegal/acc", acc, 32'h2A);

        // pc wraps 15 -> 0
        clear_im();
        m_im[0]  = e_br(7'd11, 4'd3);
        m_im[1]  = e_br(7'd12, 4'd15);
        m_im[3]  = e_mem(7'd13, 4'd0);
        m_im[15] = e_imm(7'd8, 12'd1);
        run_prog("pc_wrap");
        chk("pc_wrap/retired5", 32'(retired), 32'd5);

        // Drop run during MEM of JMP 6, then resume with a same-edge IM write at pc
        clear_im();
        m_im[0] = e_imm(7'd9, 12'd7);
        m_im[1] = e_br(7'd12, 4'd6);
        for (int unsigned i = 2; i < 6; i++) m_im[i] = e_imm(7'd9, 12'd99);
        m_im[6] = e_imm(7'd8, 12'd1);
        m_im[7] = e_mem(7'd13, 4'd0);
        jmp_word  = m_im[1];
        addi_word = m_im[6];
        reset_core();
        load_im();
        run = 1'b1;
        repeat (4) begin @(posedge clock); #1; end
        run = 1'b0;
        chk("stall/ir_jmp", inst, jmp_word);
        repeat (6) begin @(posedge clock); #1; end
        chk("stall/pc6", 32'(pc), 32'd6);
        chk("stall/inst", inst, jmp_word);
        chk("stall/retired", 32'(retired), 32'd2);
        chk("stall/acc", acc, 32'd7);
        run      = 1'b1;
        im_we    = 1'b1;
        im_waddr = 4'd6;
        im_wdata = e_imm(7'd9, 12'h123);
        @(posedge clock);
        #1;
        im_we = 1'b0;
        chk("rbw/inst_old", inst, addi_word);
        go(50, cyc);
        chk("resume/acc", acc, 32'd8);
        chk("resume/pc", 32'(pc), 32'd7);
        chk("resume/retired", 32'(retired), 32'd4);

        // Reset during EXEC of ST: store is abandoned
        clear_im();
        m_im[0] = e_imm(7'd9, 12'd9);
        m_im[1] = e_mem(7'd2, 4'd12);
        m_im[2] = e_mem(7'd1, 4'd12);
        m_im[3] = e_mem(7'd13, 4'd0);
        reset_core();
        load_im();
        run = 1'b1;
        repeat (5) begin @(posedge clock); #1; end
        reset = 1'b1;
        #1;
        check_reset("mid_reset");
        run = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b0;
        clear_im();
        m_im[0] = e_mem(7'd1, 4'd12);
        m_im[1] = e_mem(7'd13, 4'd0);
        run_prog("st_aborted");
        clear_im();
        m_im[0] = e_imm(7'd9, 12'd9);
        m_im[1] = e_mem(7'd2, 4'd12);
        m_im[2] = e_mem(7'd1, 4'd12);
        m_im[3] = e_mem(7'd13, 4'd0);
        run_prog("rerun");
        chk("rerun/acc9", acc, 32'd9);

        // Random forward-branching programs
        for (int unsigned t = 0; t < 24; t++) begin
            clear_im();
            for (int unsigned i = 0; i < 15; i++) begin
                rv = $urandom();
                case ($urandom_range(0, 15))
                    15: op = 7'($urandom_range(14, 127));
                    14: op = 7'd13;
                    default: op = 7'($urandom_range(0, 12));
                endcase
                if (op >= 7'd10 && op <= 7'd12)
                    m_im[i] = e_br(op, 4'($urandom_range(15, i + 1)));
                else if (op == 7'd8 || op == 7'd9)
                    m_im[i] = e_imm(op, rv[11:0]);
                else
                    m_im[i] = e_mem(op, rv[3:0]);
            end
            m_im[15] = e_mem(7'd13, 4'd0);
            run_prog("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
